// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants.
// RX state enum, data-bit-count helper, divisor shift.
package uart_pkg;

  localparam int UART_DIV_SHIFT = 4;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA,
    PARITY,
    STOP_BIT
  } uart_rx_state_e;

  function automatic logic [3:0] uart_num_bits(input logic [1:0] bits);
    return 4'd5 + {2'b00, bits};
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: baud counter with half/full period ticks.
// Ports: clk_i, rst_i, clr_i, restart_i, en_i, target_i -> ticks.
// UART_RX_MAJORITY_EN adds sample strobes around each point.
module uart_baud_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        restart_i,
  input  logic        en_i,
  input  logic [19:0] target_i,
  output logic        half_tick_o,
  output logic        full_tick_o
`ifdef UART_RX_MAJORITY_EN
  ,
  output logic        half_smp_o,
  output logic        full_smp_o
`endif
);

  logic [19:0] cnt;
  logic [19:0] half;

  assign half = target_i >> 1;

`ifdef UART_RX_MAJORITY_EN
  // Decision lands one cycle past centre; restart at 1 keeps
  // the next centre exactly one bit period away.
  localparam logic [19:0] RESTART = 20'd1;

  assign half_tick_o = cnt >= half + 20'd1;
  assign full_tick_o = cnt >= target_i + 20'd1;
  assign half_smp_o  = (cnt == half - 20'd1) ||
                       (cnt == half) || half_tick_o;
  assign full_smp_o  = (cnt == target_i - 20'd1) ||
                       (cnt == target_i) || full_tick_o;
`else
  localparam logic [19:0] RESTART = 20'd0;

  // >= so a shrinking divisor mid-frame cannot strand the count
  assign half_tick_o = cnt >= half;
  assign full_tick_o = cnt >= target_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clr_i) begin
      cnt <= '0;
    end else if (restart_i) begin
      cnt <= RESTART;
    end else if (en_i) begin
      cnt <= cnt + 20'd1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 5-8 data bits, optional even parity.
// Ports: clk_i, rst_i, rx_i, cfg_*, rx_data/valid/ready, err_*.
// UART_RX_MAJORITY_EN: 3-sample majority vote per bit.
module uart_rx
  import uart_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  output logic        busy_o,
  input  logic        cfg_en_i,
  input  logic [15:0] cfg_div_i,
  input  logic        cfg_parity_en_i,
  input  logic [1:0]  cfg_bits_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        err_parity_o,
  output logic        err_frame_o,
  output logic        err_overrun_o
);

  uart_rx_state_e state;

  logic        rx_m;
  logic        rx_s;
  logic [19:0] div_e;
  logic [3:0]  n_bits;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par;
  logic        perr;
  logic        armed;
  logic        active;
  logic        half_tick;
  logic        full_tick;
  logic        tick;
  logic        bit_v;

  assign div_e  = {cfg_div_i, {UART_DIV_SHIFT{1'b0}}};
  assign n_bits = uart_num_bits(cfg_bits_i);
  assign active = (state != IDLE);
  assign busy_o = active;
  assign tick   = active &&
                  ((state == START_BIT) ? half_tick : full_tick);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic       half_smp;
  logic       full_smp;
  logic       smp;
  logic [1:0] hist;

  assign smp = active &&
               ((state == START_BIT) ? half_smp : full_smp);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist <= 2'b11;
    end else if (smp) begin
      hist <= {hist[0], rx_s};
    end
  end

  // hist holds centre-1 and centre; rx_s is centre+1
  assign bit_v = (hist[1] & hist[0]) |
                 (hist[1] & rx_s) |
                 (hist[0] & rx_s);
`else
  assign bit_v = rx_s;
`endif

  uart_baud_cnt u_baud (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (!active || !cfg_en_i),
    .restart_i   (tick),
    .en_i        (active),
    .target_i    (div_e),
    .half_tick_o (half_tick),
    .full_tick_o (full_tick)
`ifdef UART_RX_MAJORITY_EN
    ,
    .half_smp_o  (half_smp),
    .full_smp_o  (full_smp)
`endif
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      par           <= 1'b0;
      perr          <= 1'b0;
      armed         <= 1'b1;
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      err_parity_o  <= 1'b0;
      err_frame_o   <= 1'b0;
      err_overrun_o <= 1'b0;
    end else begin
      if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
      if (!cfg_en_i) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            // after a break, wait for the line to go high
            if (rx_s) begin
              armed <= 1'b1;
            end else if (armed) begin
              state <= START_BIT;
            end
          end
          START_BIT: begin
            if (tick) begin
              if (bit_v) begin
                state <= IDLE;
              end else begin
                state   <= DATA;
                bit_cnt <= '0;
                par     <= 1'b0;
                perr    <= 1'b0;
              end
            end
          end
          DATA: begin
            if (tick) begin
              shreg   <= {bit_v, shreg[7:1]};
              par     <= par ^ bit_v;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt + 4'd1 >= n_bits) begin
                state <= cfg_parity_en_i ? PARITY : STOP_BIT;
              end
            end
          end
          PARITY: begin
            if (tick) begin
              perr  <= bit_v ^ par;
              state <= STOP_BIT;
            end
          end
          STOP_BIT: begin
            if (tick) begin
              rx_data_o     <= shreg >> (4'd8 - n_bits);
              err_parity_o  <= perr;
              err_frame_o   <= !bit_v;
              err_overrun_o <= rx_valid_o && !rx_ready_i;
              rx_valid_o    <= 1'b1;
              state         <= IDLE;
              if (!bit_v) begin
                armed <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: deserialises the asynchronous serial line `rx_i` into bytes using the same frame format, divisor and configuration registers as the UART transmitter. It sits inside the APB UART next to the transmitter and hands received bytes upstream (to the RX FIFO or register file) through a valid/ready handshake. It flags parity, framing and overrun errors per byte.

## Interface
- No parameters.
- `clk_i` in, 1 bit: clock.
- `rst_i` in, 1 bit: asynchronous, active-high reset.
- `rx_i` in, 1 bit: serial line, asynchronous to `clk_i`; idle level is 1.
- `busy_o` out, 1 bit: high while the FSM is not in IDLE.
- `cfg_en_i` in, 1 bit: receiver enable.
- `cfg_div_i` in, 16 bits: divisor latch; effective divisor is `E = {cfg_div_i, 4'h0}` (20 bits).
- `cfg_parity_en_i` in, 1 bit: an even parity bit follows the data bits.
- `cfg_bits_i` in, 2 bits: data bits are 00→5, 01→6, 10→7, 11→8.
- `rx_data_o` out, 8 bits: received byte, LSB first on the wire, zero-extended above the configured width.
- `rx_valid_o` out, 1 bit: byte available.
- `rx_ready_i` in, 1 bit: consumer accepts.
- `err_parity_o`, `err_frame_o`, `err_overrun_o` out, 1 bit each: status qualified by `rx_valid_o`.

## Operation
- Input path: a 2-flop synchroniser on `rx_i` feeds `rx_s`. Its reset value is 1. All decoding uses `rx_s`.
- Bit period: `P = E + 1` cycles, which matches the transmitter's bit rate. Half period: `H = E >> 1`.
- FSM states are IDLE, START_BIT, DATA, PARITY and STOP_BIT.
- IDLE → START_BIT:
  - Transition happens when `cfg_en_i` is high and `rx_s` is 0.
  - The baud counter clears to 0 on entry.
- START_BIT:
  - When the counter reaches H, sample `rx_s`.
  - If the sample is 1, the edge was a glitch: return to IDLE and produce no output.
  - If the sample is 0, go to DATA and restart the counter.
- DATA:
  - Each time the counter reaches `E` (one P period after the previous sample), sample a bit.
  - Shift the sample in at bit 7 and shift the register right.
  - Accumulate parity as the XOR of the sampled bits.
  - After N bits (N set by `cfg_bits_i`), go to PARITY if `cfg_parity_en_i` is set, else to STOP_BIT.
- PARITY:
  - Sample one bit.
  - A parity error is `sample != XOR(data bits)`, which is even parity.
- STOP_BIT:
  - Sample one bit; a framing error is `sample == 0`.
  - Always return to IDLE.
  - Only one stop bit is checked. A second stop bit is idle-high and reads as line idle.
- Output register and handshake:
  - On the stop sample, the register loads `data >> (8−N)`, together with the parity and frame flags.
  - `rx_valid_o` is then set.
  - `rx_valid_o` stays high until a cycle where `rx_valid_o && rx_ready_i`, and it clears in the following cycle.
- Overrun:
  - If a new stop sample occurs while `rx_valid_o` is high and `rx_ready_i` is low, the new byte overwrites the old one.
  - In that case `err_overrun_o` is set together with the new byte.
  - If `rx_ready_i` is high in that same cycle, the old byte counts as consumed and there is no overrun.
- Configuration changes: `cfg_*` inputs are sampled continuously. Changing them mid-frame is undefined but must not lock up the FSM; the frame ends at the latest after 11 bit periods.

## Timing
- Reset values:
  - FSM in IDLE, counter 0, `rx_s` = 1.
  - `rx_data_o` = 0.
  - `rx_valid_o`, `busy_o` and all error outputs = 0.
- Latency: `rx_valid_o` rises 1 cycle after the stop-bit sample cycle.
  - A start edge on `rx_i` reaches `rx_s` 2 cycles later.
  - The stop sample occurs H + (N + parity + 1)·P cycles after that.
- When `cfg_en_i` goes low, the next cycle has FSM = IDLE and the counter cleared. Output register and `rx_valid_o` are kept.
- Reset mid-frame returns everything to reset values immediately (asynchronously).
- The line held at 0 (break) leads to a framing error on the byte. The receiver then waits in IDLE for `rx_s` = 1 before accepting a new start bit.

## Configuration
- `UART_RX_MAJORITY_EN`:
  - Defined: each bit value is the majority of three `rx_s` samples, taken at counter values `target−1`, `target` and `target+1`. The state advances after the third sample, which adds 1 cycle to latency.
  - Undefined: single sample at `target`.

## Structure
- Shared package `uart_pkg` holds:
  - the RX state enum `uart_rx_state_e`;
  - a function mapping `cfg_bits_i` to the number of data bits;
  - the constant `UART_DIV_SHIFT = 4`.
- One sub-module, `uart_baud_cnt`, handles the baud counter:
  - inputs are the clear/enable signals and the 20-bit target;
  - it outputs the half-period and full-period tick pulses.

## Test plan
- `cfg_div_i` = 1 (P = 17), 8N1, transmit 0xA5, `rx_ready_i` = 1 → one `rx_valid_o` pulse, `rx_data_o` = 0xA5, no errors.
- 7 data bits, even parity, transmit 0x55 with the parity bit flipped → `rx_data_o` = 0x55, `err_parity_o` = 1.
- 5N1, transmit 0x13 with the stop bit forced to 0 → `rx_data_o` = 0x13, `err_frame_o` = 1; no new start is accepted until the line returns high.
- A 4-cycle low glitch on `rx_i` with P = 17 → no `rx_valid_o`, FSM back in IDLE, `busy_o` low again within H + 3 cycles.
- Two bytes 0x01 then 0x02 with `rx_ready_i` = 0 → `rx_data_o` = 0x02, `err_overrun_o` = 1; raising `rx_ready_i` for one cycle clears `rx_valid_o`.
- Assert `rst_i` in the middle of the DATA state → all outputs return to reset values; a following frame carrying 0xC3 is received correctly.
